// File: rtl/digipot_seq.sv
// ---------------------------------------------------------------------------
// digipot_seq
//
// Sequencer in front of the three-channel digipot serial writer. It keeps one
// shadow wiper byte per channel plus a pending bit per channel. Whenever a
// channel is pending, it is programmed with a single ctrl low pulse. Channels
// are served one at a time, lowest pending index first.
//
// Per transfer:
//   SETUP (1 cycle, ctrl=1) -> LOW (LOW_CYCLES, ctrl=0)
//   -> GAP (GAP_CYCLES, ctrl=1) -> IDLE (mux=11, at least 1 cycle)
//
// Ports:
//   clk      in  1  clock, all logic on posedge
//   rst      in  1  synchronous active-high reset
//   wr_en    in  1  shadow write strobe (one cycle)
//   wr_addr  in  2  channel 0..2; address 3 is ignored
//   wr_data  in  8  new wiper value
//   refresh  in  1  strobe: mark all channels pending
//   mux      out 2  channel select to the writer, 2'b11 when idle
//   ctrl     out 1  writer start, idle high, low for the frame
//   dato     out 8  byte to the writer
//   busy     out 1  FSM not idle or any channel pending
//   done     out 1  one-cycle pulse at the end of each transfer
//   done_ch  out 2  channel of the last completed transfer
//
// Parameter constraints: LOW_CYCLES >= 40 (writer frame length),
// GAP_CYCLES >= 1.
// ---------------------------------------------------------------------------
module digipot_seq #(
  parameter int         LOW_CYCLES = 44,
  parameter int         GAP_CYCLES = 4,
  parameter logic [7:0] INIT0      = 8'h80,
  parameter logic [7:0] INIT1      = 8'h80,
  parameter logic [7:0] INIT2      = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       refresh,
  output logic [1:0] mux,
  output logic       ctrl,
  output logic [7:0] dato,
  output logic       busy,
  output logic       done,
  output logic [1:0] done_ch
);

  localparam int MAX_CYCLES = (LOW_CYCLES > GAP_CYCLES) ? LOW_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [2:0][7:0]  INIT_VALS = {INIT2, INIT1, INIT0};

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_LOW, S_GAP} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       pend_reg, pend_next;
  logic [7:0]       shadow_reg [3];
  logic [1:0]       mux_reg, mux_next;
  logic [7:0]       dato_reg, dato_next;
  logic             ctrl_reg, ctrl_next;
  logic             done_reg, done_next;
  logic [1:0]       done_ch_reg, done_ch_next;

  logic [1:0]       sel_ch;
  logic             start;
  logic             wr_hit;

  assign wr_hit = wr_en && (wr_addr != 2'b11);
  assign start  = (state_reg == S_IDLE) && (pend_reg != 3'b000);

  // Lowest pending channel wins.
  always_comb begin
    sel_ch = 2'd0;
    if (pend_reg[0])      sel_ch = 2'd0;
    else if (pend_reg[1]) sel_ch = 2'd1;
    else if (pend_reg[2]) sel_ch = 2'd2;
  end

  // Shadow registers: writes are accepted in every state. The byte launched
  // on a transfer is copied into dato at SETUP entry, so later writes cannot
  // disturb a frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) shadow_reg[i] <= INIT_VALS[i];
    end else if (wr_hit) begin
      shadow_reg[wr_addr] <= wr_data;
    end
  end

  // Pending bits. The clear for the channel being launched is applied first,
  // so a same-cycle write or refresh re-arms it and forces a second transfer.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pend
      always_comb begin
        pend_next[gi] = pend_reg[gi];
        if (start && (sel_ch == 2'(gi))) pend_next[gi] = 1'b0;
        if ((wr_hit && (wr_addr == 2'(gi))) || refresh) pend_next[gi] = 1'b1;
      end
    end
  endgenerate

  // Next-state and registered-output logic.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    mux_next     = mux_reg;
    dato_next    = dato_reg;
    done_next    = 1'b0;
    done_ch_next = done_ch_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          mux_next   = sel_ch;
          dato_next  = shadow_reg[sel_ch];
          state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_next   = '0;
        state_next = S_LOW;
      end
      S_LOW: begin
        if (cnt_reg == LOW_LAST) begin
          cnt_next   = '0;
          state_next = S_GAP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next   = S_IDLE;
          mux_next     = 2'b11;
          done_next    = 1'b1;
          done_ch_next = mux_reg;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // ctrl is registered from the next state, so it is glitch-free and low
    // for exactly the cycles the FSM spends in LOW.
    ctrl_next = (state_next != S_LOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      pend_reg    <= 3'b111;
      mux_reg     <= 2'b11;
      dato_reg    <= 8'h00;
      ctrl_reg    <= 1'b1;
      done_reg    <= 1'b0;
      done_ch_reg <= 2'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pend_reg    <= pend_next;
      mux_reg     <= mux_next;
      dato_reg    <= dato_next;
      ctrl_reg    <= ctrl_next;
      done_reg    <= done_next;
      done_ch_reg <= done_ch_next;
    end
  end

  assign mux     = mux_reg;
  assign ctrl    = ctrl_reg;
  assign dato    = dato_reg;
  assign done    = done_reg;
  assign done_ch = done_ch_reg;
  assign busy    = (state_reg != S_IDLE) || (pend_reg != 3'b000);

endmodule

// File: tb/tb_digipot_seq.sv
// ---------------------------------------------------------------------------
// tb_digipot_seq
//
// Bench for digipot_seq. A monitor captures each transfer: the mux and dato
// values at the ctrl falling edge, the ctrl low length, the number of gap
// cycles before done, and done_ch. The captured transfers are compared
// against a table of expected {channel, byte} records, with one line printed
// per transfer. Hand-written sequences cover write-to-start latency and
// reset in the middle of a transfer.
// ---------------------------------------------------------------------------
module tb_digipot_seq;

  localparam int LOW_CYCLES = 44;
  localparam int GAP_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'h00;
  logic       refresh = 1'b0;
  logic [1:0] mux;
  logic       ctrl;
  logic [7:0] dato;
  logic       busy;
  logic       done;
  logic [1:0] done_ch;

  digipot_seq #(
    .LOW_CYCLES(LOW_CYCLES),
    .GAP_CYCLES(GAP_CYCLES),
    .INIT0(8'h80),
    .INIT1(8'h80),
    .INIT2(8'h80)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .refresh(refresh),
    .mux(mux),
    .ctrl(ctrl),
    .dato(dato),
    .busy(busy),
    .done(done),
    .done_ch(done_ch)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } vec_t;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
    int         low;
    int         gap;
    logic [1:0] dch;
  } obs_t;

  vec_t exp_tbl [14];
  int   exp_idx = 0;
  obs_t obs_q [$];

  int checks = 0;
  int errors = 0;

  // Monitor state
  int         phase = 0;
  int         low_cnt = 0;
  int         gap_cnt = 0;
  logic [1:0] cap_ch = 2'd0;
  logic [7:0] cap_data = 8'h00;
  int         stable_err = 0;
  int         stray_done = 0;

  always @(negedge clk) begin
    if (rst) begin
      phase = 0;
    end else begin
      if (done && phase != 2) stray_done++;
      case (phase)
        0: if (!ctrl) begin
             phase = 1; cap_ch = mux; cap_data = dato; low_cnt = 1; gap_cnt = 0;
           end
        1: if (!ctrl) begin
             low_cnt++;
             if (mux !== cap_ch || dato !== cap_data) stable_err++;
           end else begin
             phase = 2; gap_cnt = 1;
             if (mux !== cap_ch || dato !== cap_data) stable_err++;
           end
        2: if (done) begin
             obs_q.push_back('{ch: cap_ch, data: cap_data, low: low_cnt,
                               gap: gap_cnt, dch: done_ch});
             phase = 0;
           end else begin
             gap_cnt++;
             if (mux !== cap_ch || dato !== cap_data || ctrl !== 1'b1) stable_err++;
           end
        default: phase = 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((busy || phase != 0) && n < budget);
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_ctrl_low(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (ctrl && n < budget);
    chk("ctrl_fell", {31'd0, ctrl}, 32'd0);
  endtask

  task automatic verify(input int n);
    obs_t o;
    vec_t e;
    chk("xfer_count", obs_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (obs_q.size() == 0) break;
      o = obs_q.pop_front();
      e = exp_tbl[exp_idx];
      $display("xfer %0d: ch=%0d data=%02h low=%0d gap=%0d done_ch=%0d (exp ch=%0d data=%02h)",
               exp_idx, o.ch, o.data, o.low, o.gap, o.dch, e.ch, e.data);
      exp_idx++;
      chk("xfer_ch", {30'd0, o.ch}, {30'd0, e.ch});
      chk("xfer_data", {24'd0, o.data}, {24'd0, e.data});
      chk("xfer_low", o.low, LOW_CYCLES);
      chk("xfer_gap", o.gap, GAP_CYCLES);
      chk("xfer_done_ch", {30'd0, o.dch}, {30'd0, e.ch});
    end
    obs_q.delete();
    chk("idle_mux", {30'd0, mux}, 32'd3);
  endtask

  initial begin
    int drops;
    int n;

    exp_tbl[0]  = '{2'd0, 8'h80};
    exp_tbl[1]  = '{2'd1, 8'h80};
    exp_tbl[2]  = '{2'd2, 8'h80};
    exp_tbl[3]  = '{2'd1, 8'h3C};
    exp_tbl[4]  = '{2'd2, 8'h11};
    exp_tbl[5]  = '{2'd0, 8'h22};
    exp_tbl[6]  = '{2'd0, 8'hA5};
    exp_tbl[7]  = '{2'd0, 8'h55};
    exp_tbl[8]  = '{2'd0, 8'h55};
    exp_tbl[9]  = '{2'd1, 8'h3C};
    exp_tbl[10] = '{2'd2, 8'h11};
    exp_tbl[11] = '{2'd0, 8'h80};
    exp_tbl[12] = '{2'd1, 8'h80};
    exp_tbl[13] = '{2'd2, 8'h80};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mux", {30'd0, mux}, 32'd3);
    chk("rst_ctrl", {31'd0, ctrl}, 32'd1);
    chk("rst_dato", {24'd0, dato}, 32'h00);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_done_ch", {30'd0, done_ch}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;

    // After reset, all three channels are programmed with the init values.
    wait_idle(1000);
    verify(3);

    // Single write: mux/dato valid two cycles after the strobe, ctrl falls one cycle later.
    wr(2'd1, 8'h3C);
    @(posedge clk); #1;
    chk("lat_mux", {30'd0, mux}, 32'd1);
    chk("lat_dato", {24'd0, dato}, 32'h3C);
    chk("lat_ctrl_setup", {31'd0, ctrl}, 32'd1);
    @(posedge clk); #1;
    chk("lat_ctrl_low", {31'd0, ctrl}, 32'd0);
    wait_idle(500);
    verify(1);

    // Ordering: ch2 is decided first, ch0 follows.
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h11;
    @(posedge clk); #1;
    wr_addr = 2'd0; wr_data = 8'h22;
    @(posedge clk); #1;
    wr_en = 1'b0;
    wait_idle(500);
    verify(2);

    // Write during transfer, plus an ignored address-3 write.
    wr(2'd0, 8'hA5);
    wait_ctrl_low(20);
    repeat (10) @(posedge clk);
    wr(2'd0, 8'h55);
    wr(2'd3, 8'hEE);
    wait_idle(500);
    verify(2);

    // Refresh: busy must stay high until the third done.
    @(posedge clk); #1;
    refresh = 1'b1;
    @(posedge clk); #1;
    refresh = 1'b0;
    drops = 0;
    n = 0;
    while (obs_q.size() < 3 && n < 1000) begin
      @(negedge clk); #1;
      n++;
      if (obs_q.size() < 3 && !busy) drops++;
    end
    chk("refresh_busy_drops", drops, 0);
    wait_idle(100);
    verify(3);

    // Reset in the middle of a LOW phase.
    wr(2'd1, 8'h99);
    wait_ctrl_low(20);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ctrl", {31'd0, ctrl}, 32'd1);
    chk("midrst_mux", {30'd0, mux}, 32'd3);
    chk("midrst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    wait_idle(1000);
    verify(3);

    chk("mux_dato_stable", stable_err, 0);
    chk("stray_done", stray_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
